// File: rtl/audio_volume_ramp.sv
// audio_volume_ramp: multi-channel volume stage with -1.5 dB/step attenuation, per-channel mute and gain slew.
// Latency: frame accepted in cycle 0, one channel per cycle in CALC, out_valid in cycle CHANNELS+1.
// Backpressure: in_ready only in IDLE; OUT holds out_data/out_valid until out_ready, no input accepted meanwhile.
//
// Optional feature macro: VOLUME_RAMP_EN (defined = gain slews by at most RAMP_STEP per frame,
// undefined = gain jumps straight to target on every accepted frame).
//
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   in_valid/in_ready   input frame handshake; in_data packs channel c at [c*DATA_W +: DATA_W]
//   atten, mute         per-channel controls, sampled only when a frame is accepted
//   out_valid/out_ready output frame handshake; out_data uses the same packing as in_data

module audio_volume_ramp #(
    parameter int CHANNELS  = 2,
    parameter int DATA_W    = 16,
    parameter int ATTEN_W   = 6,
    parameter int RAMP_STEP = 256
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CHANNELS*DATA_W-1:0]   in_data,
    input  logic [CHANNELS*ATTEN_W-1:0]  atten,
    input  logic [CHANNELS-1:0]          mute,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CHANNELS*DATA_W-1:0]   out_data
);

    localparam int LUT_D = 1 << ATTEN_W;
    localparam int CNT_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [CNT_W-1:0] LAST_CH = CNT_W'(CHANNELS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    // Parameter sanity check at elaboration.
    if (CHANNELS < 1 || CHANNELS > 8 || RAMP_STEP < 1 || RAMP_STEP > 32768) begin : g_bad_cfg
        $error("audio_volume_ramp: CHANNELS or RAMP_STEP out of range");
    end

    // Gain for attenuation code idx: repeated multiply by 27553/32768 (~ -1.5 dB),
    // floored at each step so the table matches the integer recurrence exactly.
    function automatic logic [16:0] gain_at(input int idx);
        logic [33:0] g;
        g = 34'd32768;
        for (int i = 0; i < idx; i++) begin
            g = (g * 34'd27553) >> 15;
        end
        return g[16:0];
    endfunction

    logic [16:0] gain_lut [LUT_D];
    for (genvar i = 0; i < LUT_D; i++) begin : g_lut
        assign gain_lut[i] = gain_at(i);
    end

    // State and frame registers
    logic [1:0]                state_q, state_d;
    logic [CNT_W-1:0]          cnt_q;
    logic signed [DATA_W-1:0]  samp_q  [CHANNELS];
    logic [ATTEN_W-1:0]        atten_q [CHANNELS];
    logic [CHANNELS-1:0]       mute_q;
    logic [16:0]               cur_q   [CHANNELS];
    logic [DATA_W-1:0]         out_q   [CHANNELS];

    // Datapath for the channel selected by cnt_q (one shared multiplier)
    logic signed [DATA_W-1:0]  samp_sel;
    logic [16:0]               cur_sel;
    logic [16:0]               target;
    logic [16:0]               cur_new;
    logic signed [DATA_W+17:0] mul_a;
    logic signed [DATA_W+17:0] mul_b;
    logic signed [DATA_W+17:0] prod;
    logic [DATA_W-1:0]         out_new;

`ifdef VOLUME_RAMP_EN
    localparam logic signed [18:0] STEP = 19'(RAMP_STEP);
    logic signed [18:0] diff;
`endif

    always_comb begin
        samp_sel = samp_q[cnt_q];
        cur_sel  = cur_q[cnt_q];
        target   = mute_q[cnt_q] ? 17'd0 : gain_lut[atten_q[cnt_q]];
`ifdef VOLUME_RAMP_EN
        // Only step when strictly farther than STEP away; otherwise land on target,
        // so the gain can neither overshoot nor leave 0..32768.
        diff = $signed({2'b00, target}) - $signed({2'b00, cur_sel});
        if (diff > STEP) begin
            cur_new = cur_sel + 17'(RAMP_STEP);
        end else if (diff < -STEP) begin
            cur_new = cur_sel - 17'(RAMP_STEP);
        end else begin
            cur_new = target;
        end
`else
        cur_new = target;
`endif
        // Signed sample times unsigned gain; gain is zero-extended so it stays positive.
        mul_a   = {{18{samp_sel[DATA_W-1]}}, samp_sel};
        mul_b   = $signed({{(DATA_W + 1){1'b0}}, cur_new});
        prod    = mul_a * mul_b;
        // Arithmetic shift floors toward -inf; gain <= 1.0 so truncation cannot overflow.
        out_new = DATA_W'(prod >>> 15);
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid) state_d = S_CALC;
            S_CALC:  if (cnt_q == LAST_CH) state_d = S_OUT;
            S_OUT:   if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mute_q  <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                samp_q[c]  <= '0;
                atten_q[c] <= '0;
                cur_q[c]   <= '0;
                out_q[c]   <= '0;
            end
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        cnt_q  <= '0;
                        mute_q <= mute;
                        for (int c = 0; c < CHANNELS; c++) begin
                            samp_q[c]  <= in_data[c*DATA_W +: DATA_W];
                            atten_q[c] <= atten[c*ATTEN_W +: ATTEN_W];
                        end
                    end
                end
                S_CALC: begin
                    cur_q[cnt_q] <= cur_new;
                    out_q[cnt_q] <= out_new;
                    if (cnt_q != LAST_CH) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_OUT);

    always_comb begin
        out_data = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            out_data[c*DATA_W +: DATA_W] = out_q[c];
        end
    end

endmodule

// File: tb/tb_audio_volume_ramp.sv
// Directed bench for audio_volume_ramp (CHANNELS=2, DATA_W=16, ATTEN_W=6, RAMP_STEP=256).
// Each frame is checked against hand constants and a small gain model.
// Ramp scenarios run when VOLUME_RAMP_EN is defined, fixed-gain scenarios otherwise.

module tb_audio_volume_ramp;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [11:0] atten;
    logic [1:0]  mute;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    int checks = 0;
    int errors = 0;
    int mcur [2];

    always #5 clk = ~clk;

    audio_volume_ramp #(
        .CHANNELS(2), .DATA_W(16), .ATTEN_W(6), .RAMP_STEP(256)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .atten(atten), .mute(mute),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    function automatic int lut_gain(input int a);
        int g;
        g = 32768;
        for (int i = 0; i < a; i++) g = (g * 27553) >>> 15;
        return g;
    endfunction

    function automatic int model_step(input int cur, input int tgt);
`ifdef VOLUME_RAMP_EN
        if (tgt - cur > 256) return cur + 256;
        if (tgt - cur < -256) return cur - 256;
        return tgt;
`else
        return tgt;
`endif
    endfunction

    function automatic logic signed [15:0] scale(input logic signed [15:0] s, input int g);
        longint p;
        p = longint'(s) * longint'(g);
        return 16'(p >>> 15);
    endfunction

    // Sends one frame, checks latency, model outputs, optional hold stability and ready return.
    task automatic do_frame(input logic signed [15:0] s0, input logic signed [15:0] s1,
                            input logic [5:0] a0, input logic [5:0] a1,
                            input logic m0, input logic m1, input int hold,
                            output logic signed [15:0] o0, output logic signed [15:0] o1);
        int n;
        logic [31:0] snap;
        logic signed [15:0] e0, e1;
        mcur[0] = model_step(mcur[0], m0 ? 0 : lut_gain(int'(a0)));
        mcur[1] = model_step(mcur[1], m1 ? 0 : lut_gain(int'(a1)));
        e0 = scale(s0, mcur[0]);
        e1 = scale(s1, mcur[1]);
        @(negedge clk);
        in_valid = 1'b1; in_data = {s1, s0}; atten = {a1, a0}; mute = {m1, m0};
        n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL accept_timeout: in_ready=%b required 1", in_ready); end
        @(posedge clk);
        @(negedge clk);
        // Controls change after acceptance; they must not affect this frame.
        in_valid = 1'b0; in_data = $urandom; atten = 12'($urandom); mute = 2'($urandom);
        n = 1;
        while (!out_valid && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (n !== 3) begin errors++; $display("FAIL latency: got cycle %0d required 3", n); end
        snap = out_data;
        o0 = out_data[15:0];
        o1 = out_data[31:16];
        checks++;
        if (o0 !== e0) begin errors++; $display("FAIL model_ch0: got %0d required %0d", o0, e0); end
        checks++;
        if (o1 !== e1) begin errors++; $display("FAIL model_ch1: got %0d required %0d", o1, e1); end
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1; in_data = $urandom;
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== snap || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_stable: out_valid=%b out_data=%h in_ready=%b required 1 %h 0",
                         out_valid, out_data, in_ready, snap);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL after_handshake: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; atten = '0; mute = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b out_data=%h required 1 0 0",
                     in_ready, out_valid, out_data);
        end
        rst = 1'b0;
        mcur[0] = 0; mcur[1] = 0;
    endtask

`ifndef VOLUME_RAMP_EN
    task automatic test_unity;
        logic signed [15:0] o0, o1;
        do_frame(16'sd16384, -16'sd32768, 6'd0, 6'd0, 1'b0, 1'b0, 0, o0, o1);
        checks++;
        if (o0 !== 16'sd16384) begin errors++; $display("FAIL unity_16384: got %0d required 16384", o0); end
        checks++;
        if (o1 !== -16'sd32768) begin errors++; $display("FAIL unity_min: got %0d required -32768", o1); end
        do_frame(-16'sd1, 16'sd0, 6'd0, 6'd0, 1'b0, 1'b0, 0, o0, o1);
        checks++;
        if (o0 !== -16'sd1) begin errors++; $display("FAIL unity_m1: got %0d required -1", o0); end
    endtask

    task automatic test_atten;
        logic signed [15:0] o0, o1;
        do_frame(16'sd32767, -16'sd1, 6'd1, 6'd1, 1'b0, 1'b0, 0, o0, o1);
        checks++;
        if (o0 !== 16'sd27552) begin errors++; $display("FAIL atten1_max: got %0d required 27552", o0); end
        checks++;
        if (o1 !== -16'sd1) begin errors++; $display("FAIL atten1_m1: got %0d required -1", o1); end
        do_frame(16'sd32767, -16'sd32768, 6'd63, 6'd63, 1'b0, 1'b0, 0, o0, o1);
        do_frame(16'sd20000, -16'sd20000, 6'd2, 6'd5, 1'b1, 1'b0, 0, o0, o1);
        checks++;
        if (o0 !== 16'sd0) begin errors++; $display("FAIL mute_ch0: got %0d required 0", o0); end
    endtask
`else
    task automatic test_ramp_up;
        logic signed [15:0] o0, o1, prev;
        test_reset();
        prev = 16'sd0;
        for (int f = 1; f <= 130; f++) begin
            do_frame(16'sd32767, 16'sd32767, 6'd0, 6'd0, 1'b0, 1'b0, 0, o0, o1);
            if (f == 1) begin
                checks++;
                if (o0 !== 16'sd255) begin errors++; $display("FAIL ramp_first: got %0d required 255", o0); end
            end
            checks++;
            if (o0 < prev) begin errors++; $display("FAIL ramp_monotonic: frame %0d got %0d below %0d", f, o0, prev); end
            if (f >= 128) begin
                checks++;
                if (o0 !== 16'sd32767) begin errors++; $display("FAIL ramp_settled: frame %0d got %0d required 32767", f, o0); end
            end
            prev = o0;
        end
    endtask

    task automatic test_mute_ramp;
        logic signed [15:0] o0, o1, prev;
        prev = 16'sd32767;
        for (int f = 1; f <= 130; f++) begin
            do_frame(16'sd32767, 16'sd32767, 6'd0, 6'd0, 1'b1, 1'b0, 0, o0, o1);
            checks++;
            if (int'(prev) - int'(o0) < 0 || int'(prev) - int'(o0) > 256) begin
                errors++; $display("FAIL mute_step: frame %0d got %0d after %0d", f, o0, prev);
            end
            if (f >= 128) begin
                checks++;
                if (o0 !== 16'sd0) begin errors++; $display("FAIL mute_zero: frame %0d got %0d required 0", f, o0); end
            end
            checks++;
            if (o1 !== 16'sd32767) begin errors++; $display("FAIL mute_other_ch: frame %0d got %0d required 32767", f, o1); end
            prev = o0;
        end
    endtask
`endif

    task automatic test_backpressure;
        logic signed [15:0] o0, o1;
        do_frame(16'sd1234, -16'sd5678, 6'd3, 6'd5, 1'b0, 1'b0, 5, o0, o1);
        do_frame(-16'sd9999, 16'sd7777, 6'd0, 6'd10, 1'b0, 1'b0, 0, o0, o1);
    endtask

    task automatic test_reset_mid_calc;
        logic signed [15:0] o0, o1;
        int n;
        @(negedge clk);
        in_valid = 1'b1; in_data = {16'sd1000, 16'sd1000}; atten = '0; mute = '0;
        n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL midcalc_out_valid: got %b required 0", out_valid); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL midcalc_in_ready: got %b required 1", in_ready); end
        checks++;
        if (out_data !== 32'h0) begin errors++; $display("FAIL midcalc_out_data: got %h required 0", out_data); end
        mcur[0] = 0; mcur[1] = 0;
        do_frame(16'sd32767, 16'sd32767, 6'd0, 6'd0, 1'b0, 1'b0, 0, o0, o1);
        checks++;
`ifdef VOLUME_RAMP_EN
        if (o0 !== 16'sd255) begin errors++; $display("FAIL midcalc_restart: got %0d required 255", o0); end
`else
        if (o0 !== 16'sd32767) begin errors++; $display("FAIL midcalc_restart: got %0d required 32767", o0); end
`endif
    endtask

    initial begin
        test_reset();
`ifdef VOLUME_RAMP_EN
        test_ramp_up();
        test_mute_ramp();
`else
        test_unity();
        test_atten();
`endif
        test_backpressure();
        test_reset_mid_calc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/audio_volume_ramp.md
# audio_volume_ramp

Parametrised multi-channel volume stage for the Toccata audio path. It applies −1.5 dB-per-step attenuation and per-channel mute to a frame of signed PCM samples. On every accepted frame, each channel's gain slews toward its target in bounded steps, which removes zipper noise and clicks. One shared multiplier is time-multiplexed across channels, and frames pass through valid/ready handshakes between the Toccata sample source and the mixer.

## Interface
- CHANNELS, 2, number of audio channels per frame (1..8)
- DATA_W, 16, signed sample width per channel (8..24)
- ATTEN_W, 6, attenuation code width; LUT depth 2^ATTEN_W
- RAMP_STEP, 256, maximum gain change per frame, Q1.15 units (1..32768)
- clk  in  1  system clock; single clock domain
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input frame valid
- in_ready  out  1  block can accept a frame
- in_data  in  CHANNELS*DATA_W  signed samples; channel c occupies bits [c*DATA_W +: DATA_W]
- atten  in  CHANNELS*ATTEN_W  per-channel attenuation code; 0 = 0 dB
- mute  in  CHANNELS  per-channel mute; 1 = target gain 0
- out_valid  out  1  output frame valid
- out_ready  in  1  downstream accepts frame
- out_data  out  CHANNELS*DATA_W  attenuated signed samples, same packing as in_data

## Operation
- Gain LUT, unsigned Q1.15, 17 bits:
  - g[0] = 32768.
  - g[i] = (g[i−1] × 27553) >> 15.
  - Examples: g[1] = 27553, g[2] = 23167.
  - Computed at elaboration.
- Per-channel target = mute[c] ? 0 : g[atten[c]].
- Per-channel registered current gain cur[c], 17 bits.
- FSM states:
  - IDLE: in_ready = 1. When in_valid, capture in_data, atten and mute, reset the channel counter to 0, then go to CALC.
  - CALC: one channel per cycle, counter 0..CHANNELS−1. Each cycle, update cur[c] per the ramp rule, then compute out[c] using the updated gain. After the last channel, go to OUT.
  - OUT: out_valid = 1; out_data is held. When out_ready, go to IDLE.
- Ramp rule, for d = target − cur[c]:
  - If |d| ≤ RAMP_STEP, cur[c] = target.
  - Otherwise cur[c] moves by ±RAMP_STEP toward target.
  - cur[c] never overshoots and never leaves 0..32768.
- Arithmetic: out[c] = (sample × cur) >>> 15.
  - Sample is signed DATA_W, cur is unsigned 17 bits; product is a signed DATA_W+18-bit value.
  - The shift is arithmetic (floor toward −∞); the result is truncated to DATA_W.
  - No overflow is possible because cur ≤ 32768.
  - Example: −1 × 27553 → −1.
- Control inputs (atten, mute) are sampled only at frame acceptance. Changes during CALC or OUT affect the next frame only.
- Gains update once per accepted frame, never while idle.

## Timing
- Reset values:
  - State IDLE, in_ready = 1.
  - out_valid = 0, out_data = 0.
  - All cur[c] = 0, so the first frames after reset ramp up from silence.
- Latency:
  - Frame accepted at cycle 0 (in_valid & in_ready).
  - CALC occupies cycles 1..CHANNELS.
  - out_valid rises at cycle CHANNELS+1.
- Throughput: one frame per CHANNELS+2 cycles with out_ready held high.
- in_ready is high only in IDLE. It reasserts the cycle after the out handshake, so there is no combinational ready path.
- While out_valid = 1 and out_ready = 0, out_data and out_valid are stable and no input is accepted.
- If rst asserts in any state, the block returns to the reset values on the next edge. A partially computed frame is discarded and never emitted.
- in_valid asserted during CALC or OUT is ignored; the source must hold it until in_ready.

## Configuration
- VOLUME_RAMP_EN defined: slew behaviour as specified above.
- VOLUME_RAMP_EN undefined:
  - cur[c] = target on every accepted frame; RAMP_STEP is unused.
  - Reset still clears cur[c] to 0, but the first frame already uses the full target gain.
  - FSM, latency and handshake are unchanged.

## Test plan
- Ramp disabled, atten = 0, mute = 0: in 16384 → out 16384; in −32768 → −32768; in −1 → −1. Latency is CHANNELS+1 cycles.
- Ramp disabled, atten = 1: in 32767 → 27552; in −1 → −1. Also check atten = 63 on both channels against the LUT model.
- Ramp enabled, RAMP_STEP = 256, after reset, constant in 32767, atten = 0:
  - Frame 1 → 255.
  - Frame 128 and later → 32767.
  - Output is monotonic in between.
- Ramp enabled, steady gain 32768, then mute[0] = 1 with in 32767:
  - Channel 0 decreases by ≤ 256 gain per frame and is 0 from frame 128 onward.
  - Channel 1 is unaffected.
- Backpressure: hold out_ready = 0 for 5 cycles in OUT. out_data and out_valid stay stable, in_ready = 0, and no frame is lost or duplicated against the reference model.
- Assert rst for one cycle during CALC. Next cycle: out_valid = 0, in_ready = 1, out_data = 0. The next frame ramps from gain 0.
